reg_alu_seq: RTL and testbench

//  Command sequencer for the reg_alu datapath (8x16 register file + 2-bit-op ALU).

---
 rtl/reg_alu_seq_pkg.sv | 35 +++
 rtl/iter_cnt.sv | 29 ++
 rtl/reg_alu_seq.sv | 143 ++++++++++++++
 tb/tb_reg_alu_seq.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_alu_seq_pkg.sv
// Shared encodings for the reg_alu command sequencer.
// No logic; types and constants only.
// Used by the sequencer top and its testbench.
package reg_alu_seq_pkg;

  // Sequencer states (2-bit encoding)
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Command kinds
  typedef enum logic {
    K_LOAD = 1'b0,
    K_ALU  = 1'b1
  } kind_t;

  // reg_alu op codes; the sequencer forwards op untouched, these are for reference
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_OR  = 2'd3;

  // Latched command fields (repeat count lives in the iteration counter)
  typedef struct packed {
    kind_t       kind;
    logic [1:0]  op;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [2:0]  rd;
    logic [15:0] imm;
  } cmd_t;

endpackage

// File: rtl/iter_cnt.sv
// Loadable down counter with zero flag for the sequencer's repeat count.
// Latency: load/decrement visible one cycle after the enabling edge.
// No backpressure; saturates at zero instead of wrapping.
module iter_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  // Load has priority over decrement; decrement stops at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/reg_alu_seq.sv
// Command sequencer driving reg_alu: immediate loads and repeated rd = rd op rb.
// Latency: accept at T, first write at T+1, done pulse in cycle T+2+cnt (LOAD: T+2).
// Backpressure: cmd_ready only in IDLE; one command in flight at a time.
module reg_alu_seq
  import reg_alu_seq_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_kind,
  input  logic [1:0]       cmd_op,
  input  logic [2:0]       cmd_ra,
  input  logic [2:0]       cmd_rb,
  input  logic [2:0]       cmd_rd,
  input  logic [15:0]      cmd_imm,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic             abort,
  output logic             sel,
  output logic             wr,
  output logic [1:0]       op,
  output logic [2:0]       rd_addr_a,
  output logic [2:0]       rd_addr_b,
  output logic [2:0]       wr_addr,
  output logic [15:0]      d_in,
  input  logic             cout,
  output logic             busy,
  output logic             done,
  output logic             carry_flag,
  output logic             aborted
);

  state_t           state_q;
  state_t           state_d;
  cmd_t             cmd_q;
  logic             first_q;
  logic             accept;
  logic             in_exec;
  logic             is_alu;
  logic             cnt_zero;
  logic [CNT_W-1:0] cnt_val;

  assign accept  = cmd_valid && (state_q == S_IDLE);
  assign in_exec = (state_q == S_EXEC);
  assign is_alu  = (cmd_q.kind == K_ALU);

  // Remaining iterations after the current one; loaded at accept
  iter_cnt #(
    .CNT_W (CNT_W)
  ) u_iter_cnt (
    .clk      (clk),
    .rst_n    (reset),
    .load     (accept),
    .load_val (cmd_cnt),
    .dec      (in_exec && is_alu),
    .cnt      (cnt_val),
    .zero     (cnt_zero)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: LOAD is a single EXEC cycle, ALU runs until the counter hits zero
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_EXEC;
      end
      S_EXEC: begin
        if (abort || !is_alu || cnt_zero) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Command latch, first-iteration marker and sticky status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmd_q      <= '0;
      first_q    <= 1'b0;
      carry_flag <= 1'b0;
      aborted    <= 1'b0;
    end else if (accept) begin
      cmd_q.kind <= kind_t'(cmd_kind);
      cmd_q.op   <= cmd_op;
      cmd_q.ra   <= cmd_ra;
      cmd_q.rb   <= cmd_rb;
      cmd_q.rd   <= cmd_rd;
      cmd_q.imm  <= cmd_imm;
      first_q    <= 1'b1;
      carry_flag <= 1'b0;
      aborted    <= 1'b0;
    end else if (in_exec) begin
      first_q <= 1'b0;
      if (abort) begin
        aborted <= 1'b1;
      end else if (is_alu) begin
        carry_flag <= carry_flag | cout;
      end
    end
  end

  // Datapath controls decode only from state and latched fields; abort gates wr alone
  always_comb begin
    cmd_ready = (state_q == S_IDLE);
    busy      = (state_q == S_EXEC) || (state_q == S_DONE);
    done      = (state_q == S_DONE);
    sel       = 1'b0;
    wr        = 1'b0;
    op        = 2'd0;
    rd_addr_a = 3'd0;
    rd_addr_b = 3'd0;
    wr_addr   = 3'd0;
    d_in      = 16'd0;
    if (in_exec) begin
      wr      = !abort;
      wr_addr = cmd_q.rd;
      if (is_alu) begin
        sel       = 1'b1;
        op        = cmd_q.op;
        rd_addr_b = cmd_q.rb;
        rd_addr_a = first_q ? cmd_q.ra : cmd_q.rd;
      end else begin
        d_in = cmd_q.imm;
      end
    end
  end

endmodule

// File: tb/tb_reg_alu_seq.sv
module tb_reg_alu_seq;
  import reg_alu_seq_pkg::*;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_kind = 1'b0;
  logic [1:0]       cmd_op = 2'd0;
  logic [2:0]       cmd_ra = 3'd0;
  logic [2:0]       cmd_rb = 3'd0;
  logic [2:0]       cmd_rd = 3'd0;
  logic [15:0]      cmd_imm = 16'd0;
  logic [CNT_W-1:0] cmd_cnt = '0;
  logic             abort = 1'b0;
  logic             sel, wr, cout, busy, done, carry_flag, aborted;
  logic [1:0]       op;
  logic [2:0]       rd_addr_a, rd_addr_b, wr_addr;
  logic [15:0]      d_in;

  int n_checks = 0;
  int n_fail   = 0;

  // observations collected by run_cmd
  int          n_wr;
  int          done_k;
  logic [2:0]  obs_a [0:31];
  logic        obs_sel [0:31];
  logic [2:0]  obs_waddr [0:31];
  logic [15:0] obs_din [0:31];
  logic        obs_carry, obs_aborted, obs_rdy, obs_busy;

  always #5 clk = ~clk;

  reg_alu_seq #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_kind(cmd_kind), .cmd_op(cmd_op), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
    .cmd_rd(cmd_rd), .cmd_imm(cmd_imm), .cmd_cnt(cmd_cnt), .abort(abort),
    .sel(sel), .wr(wr), .op(op), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .wr_addr(wr_addr), .d_in(d_in), .cout(cout), .busy(busy), .done(done),
    .carry_flag(carry_flag), .aborted(aborted)
  );

  // reg_alu stand-in: 8x16 register file, 2-bit-op ALU, untouched by sequencer reset
  logic [15:0] rf [0:7] = '{default: 16'h0000};
  logic [15:0] a_val, b_val;
  logic [16:0] alu_full;
  always_comb begin
    a_val = rf[rd_addr_a];
    b_val = rf[rd_addr_b];
    case (op)
      OP_ADD:  alu_full = {1'b0, a_val} + {1'b0, b_val};
      OP_SUB:  alu_full = {1'b0, a_val} - {1'b0, b_val};
      OP_AND:  alu_full = {1'b0, a_val & b_val};
      default: alu_full = {1'b0, a_val | b_val};
    endcase
  end
  assign cout = alu_full[16];
  always @(posedge clk) if (wr) rf[wr_addr] <= sel ? alu_full[15:0] : d_in;

  // Issue one command, then watch cycles k=1.. after the accept edge until done
  task automatic run_cmd(input logic kind, input logic [1:0] o, input logic [2:0] ra,
                         input logic [2:0] rb, input logic [2:0] rd, input logic [15:0] imm,
                         input logic [CNT_W-1:0] cnt, input int abort_k);
    int guard;
    n_wr = 0; done_k = 0; guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (!cmd_ready) begin
      n_fail++;
      $display("FAIL ready_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, guard);
    end
    cmd_kind = kind; cmd_op = o; cmd_ra = ra; cmd_rb = rb; cmd_rd = rd;
    cmd_imm = imm; cmd_cnt = cnt; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      abort = (k == abort_k);
      #1;
      if (wr) begin
        if (n_wr < 32) begin
          obs_a[n_wr] = rd_addr_a; obs_sel[n_wr] = sel;
          obs_waddr[n_wr] = wr_addr; obs_din[n_wr] = d_in;
        end
        n_wr++;
      end
      if (done) begin
        done_k = k; obs_carry = carry_flag; obs_aborted = aborted;
        obs_rdy = cmd_ready; obs_busy = busy;
        break;
      end
      @(negedge clk);
    end
    abort = 1'b0;
    n_checks++;
    if (done_k == 0) begin
      n_fail++;
      $display("FAIL done_timeout: done not seen within 40 cycles, required a pulse");
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({cmd_ready, busy, done, wr, sel, carry_flag, aborted} !== 7'b1000000) begin
      n_fail++;
      $display("FAIL reset_flags: got rdy/busy/done/wr/sel/cf/ab=%b required 1000000",
               {cmd_ready, busy, done, wr, sel, carry_flag, aborted});
    end
    n_checks++;
    if ({op, rd_addr_a, rd_addr_b, wr_addr, d_in} !== 27'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got op/addr/d_in=%h required 0", {op, rd_addr_a, rd_addr_b, wr_addr, d_in});
    end
    reset = 1'b1;
  endtask

  task automatic test_load();
    run_cmd(K_LOAD, 2'd0, 3'd0, 3'd0, 3'd3, 16'hA5A5, 4'd9, 0);
    n_checks++;
    if (n_wr !== 1 || done_k !== 2) begin
      n_fail++;
      $display("FAIL load_timing: got writes=%0d done_k=%0d required 1, 2", n_wr, done_k);
    end
    n_checks++;
    if (obs_sel[0] !== 1'b0 || obs_waddr[0] !== 3'd3 || obs_din[0] !== 16'hA5A5) begin
      n_fail++;
      $display("FAIL load_ctrl: got sel=%b wr_addr=%0d d_in=%h required 0, 3, a5a5",
               obs_sel[0], obs_waddr[0], obs_din[0]);
    end
    n_checks++;
    if (rf[3] !== 16'hA5A5) begin
      n_fail++;
      $display("FAIL load_reg3: got %h required a5a5", rf[3]);
    end
  endtask

  task automatic test_alu_single();
    run_cmd(K_LOAD, 2'd0, 3'd0, 3'd0, 3'd1, 16'd5, 4'd0, 0);
    run_cmd(K_LOAD, 2'd0, 3'd0, 3'd0, 3'd2, 16'd7, 4'd0, 0);
    run_cmd(K_ALU, OP_ADD, 3'd1, 3'd2, 3'd4, 16'd0, 4'd0, 0);
    n_checks++;
    if (n_wr !== 1 || done_k !== 2 || rf[4] !== 16'd12) begin
      n_fail++;
      $display("FAIL alu_single: got writes=%0d done_k=%0d r4=%0d required 1, 2, 12", n_wr, done_k, rf[4]);
    end
    n_checks++;
    if (obs_a[0] !== 3'd1 || obs_sel[0] !== 1'b1 || obs_carry !== 1'b0) begin
      n_fail++;
      $display("FAIL alu_single_ctrl: got a=%0d sel=%b carry=%b required 1, 1, 0", obs_a[0], obs_sel[0], obs_carry);
    end
  endtask

  task automatic test_alu_repeat();
    run_cmd(K_LOAD, 2'd0, 3'd0, 3'd0, 3'd1, 16'd1, 4'd0, 0);
    run_cmd(K_LOAD, 2'd0, 3'd0, 3'd0, 3'd2, 16'd3, 4'd0, 0);
    run_cmd(K_ALU, OP_ADD, 3'd1, 3'd2, 3'd1, 16'd0, 4'd3, 0);
    n_checks++;
    if (n_wr !== 4 || done_k !== 5 || rf[1] !== 16'd13) begin
      n_fail++;
      $display("FAIL alu_repeat: got writes=%0d done_k=%0d r1=%0d required 4, 5, 13", n_wr, done_k, rf[1]);
    end
  endtask

  task automatic test_carry();
    run_cmd(K_LOAD, 2'd0, 3'd0, 3'd0, 3'd1, 16'hFFF0, 4'd0, 0);
    run_cmd(K_LOAD, 2'd0, 3'd0, 3'd0, 3'd2, 16'h0008, 4'd0, 0);
    run_cmd(K_ALU, OP_ADD, 3'd1, 3'd1, 3'd1, 16'd0, 4'd1, 0);
    n_checks++;
    if (obs_carry !== 1'b1 || rf[1] !== 16'hFFC0 || n_wr !== 2) begin
      n_fail++;
      $display("FAIL carry: got carry=%b r1=%h writes=%0d required 1, ffc0, 2", obs_carry, rf[1], n_wr);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (carry_flag !== 1'b1 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL carry_hold: got carry=%b rdy=%b in IDLE required 1, 1", carry_flag, cmd_ready);
    end
    run_cmd(K_LOAD, 2'd0, 3'd0, 3'd0, 3'd7, 16'h0001, 4'd0, 0);
    n_checks++;
    if (obs_carry !== 1'b0) begin
      n_fail++;
      $display("FAIL carry_clear: got carry=%b after new command required 0", obs_carry);
    end
  endtask

  task automatic test_abort();
    run_cmd(K_LOAD, 2'd0, 3'd0, 3'd0, 3'd2, 16'd1, 4'd0, 0);
    run_cmd(K_LOAD, 2'd0, 3'd0, 3'd0, 3'd5, 16'h1234, 4'd0, 0);
    run_cmd(K_ALU, OP_ADD, 3'd2, 3'd2, 3'd5, 16'd0, 4'd15, 3);
    n_checks++;
    if (n_wr !== 2 || done_k !== 4 || obs_aborted !== 1'b1) begin
      n_fail++;
      $display("FAIL abort: got writes=%0d done_k=%0d aborted=%b required 2, 4, 1", n_wr, done_k, obs_aborted);
    end
    n_checks++;
    if (obs_a[0] !== 3'd2 || obs_a[1] !== 3'd5 || rf[5] !== 16'd3) begin
      n_fail++;
      $display("FAIL abort_src: got a0=%0d a1=%0d r5=%0d required 2, 5, 3", obs_a[0], obs_a[1], rf[5]);
    end
  endtask

  task automatic test_max_count();
    run_cmd(K_LOAD, 2'd0, 3'd0, 3'd0, 3'd6, 16'd0, 4'd0, 0);
    run_cmd(K_LOAD, 2'd0, 3'd0, 3'd0, 3'd7, 16'd1, 4'd0, 0);
    run_cmd(K_ALU, OP_ADD, 3'd6, 3'd7, 3'd6, 16'd0, 4'd15, 0);
    n_checks++;
    if (n_wr !== 16 || done_k !== 17 || rf[6] !== 16'd16 || obs_aborted !== 1'b0) begin
      n_fail++;
      $display("FAIL max_count: got writes=%0d done_k=%0d r6=%0d aborted=%b required 16, 17, 16, 0",
               n_wr, done_k, rf[6], obs_aborted);
    end
  endtask

  task automatic test_back_to_back();
    run_cmd(K_LOAD, 2'd0, 3'd0, 3'd0, 3'd0, 16'hBEEF, 4'd0, 0);
    n_checks++;
    if (obs_rdy !== 1'b0 || obs_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL done_cycle: got rdy=%b busy=%b during done required 0, 1", obs_rdy, obs_busy);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL after_done: got rdy=%b busy=%b done=%b required 1, 0, 0", cmd_ready, busy, done);
    end
  endtask

  task automatic test_reset_mid();
    run_cmd(K_LOAD, 2'd0, 3'd0, 3'd0, 3'd6, 16'd0, 4'd0, 0);
    run_cmd(K_LOAD, 2'd0, 3'd0, 3'd0, 3'd7, 16'd1, 4'd0, 0);
    @(negedge clk);
    cmd_kind = K_ALU; cmd_op = OP_ADD; cmd_ra = 3'd6; cmd_rb = 3'd7; cmd_rd = 3'd6;
    cmd_cnt = 4'd10; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({wr, sel, busy, done, cmd_ready} !== 5'b00001 || {op, rd_addr_a, rd_addr_b, wr_addr} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_async: got wr/sel/busy/done/rdy=%b ctrl=%h required 00001, 0",
               {wr, sel, busy, done, cmd_ready}, {op, rd_addr_a, rd_addr_b, wr_addr});
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (rf[6] !== 16'd2 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_drop: got r6=%0d rdy=%b required 2, 1", rf[6], cmd_ready);
    end
    run_cmd(K_ALU, OP_ADD, 3'd6, 3'd7, 3'd6, 16'd0, 4'd0, 0);
    n_checks++;
    if (rf[6] !== 16'd3 || done_k !== 2 || n_wr !== 1) begin
      n_fail++;
      $display("FAIL reset_resume: got r6=%0d done_k=%0d writes=%0d required 3, 2, 1", rf[6], done_k, n_wr);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_alu_single();
    test_alu_repeat();
    test_carry();
    test_abort();
    test_max_count();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
